// File: rtl/mc_minmax_scheduler_if.sv
// Valid/ready stream bundle for mc_minmax_scheduler: sample input side and result output side.
// The master modport drives samples and accepts results; the slave modport is the scheduler.
interface mc_minmax_scheduler_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned IDX_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] max_val;
   logic [WIDTH-1:0] min_val;
   logic [IDX_W-1:0] max_idx;
   logic [IDX_W-1:0] min_idx;
   logic             all_equal;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  max_val,
      input  min_val,
      input  max_idx,
      input  min_idx,
      input  all_equal
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output max_val,
      output min_val,
      output max_idx,
      output min_idx,
      output all_equal
   );
endinterface

// File: rtl/mc_minmax_scheduler.sv
// Frame min/max tracker: one shared unsigned comparator, used first against the running
// maximum and then against the running minimum for every sample after the first.
module mc_minmax_scheduler #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned FRAME_LEN = 8,
   parameter int unsigned IDX_W     = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   output logic                  o_busy,
   mc_minmax_scheduler_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StCmpMax,
      StCmpMin,
      StDone
   } state_e;

   state_e           r_state, w_state_d;
   logic [CNT_W-1:0] r_count, w_count_d;
   logic [WIDTH-1:0] r_sample, w_sample_d;
   logic [IDX_W-1:0] r_index, w_index_d;
   logic [WIDTH-1:0] r_max, w_max_d;
   logic [WIDTH-1:0] r_min, w_min_d;
   logic [IDX_W-1:0] r_max_idx, w_max_idx_d;
   logic [IDX_W-1:0] r_min_idx, w_min_idx_d;
   logic             r_all_eq, w_all_eq_d;

   // Single shared comparator; operand B follows the phase of the schedule.
   logic [WIDTH-1:0] w_opa;
   logic [WIDTH-1:0] w_opb;
   logic             w_gt;
   logic             w_eq;
   logic             w_lt;

   assign w_opa = r_sample;
   assign w_opb = (r_state == StCmpMin) ? r_min : r_max;
   assign w_gt  = (w_opa > w_opb);
   assign w_eq  = (w_opa == w_opb);
   assign w_lt  = (w_opa < w_opb);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= StIdle;
         r_count   <= '0;
         r_sample  <= '0;
         r_index   <= '0;
         r_max     <= '0;
         r_min     <= '0;
         r_max_idx <= '0;
         r_min_idx <= '0;
         r_all_eq  <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_count   <= w_count_d;
         r_sample  <= w_sample_d;
         r_index   <= w_index_d;
         r_max     <= w_max_d;
         r_min     <= w_min_d;
         r_max_idx <= w_max_idx_d;
         r_min_idx <= w_min_idx_d;
         r_all_eq  <= w_all_eq_d;
      end
   end

   always_comb begin
      w_state_d   = r_state;
      w_count_d   = r_count;
      w_sample_d  = r_sample;
      w_index_d   = r_index;
      w_max_d     = r_max;
      w_min_d     = r_min;
      w_max_idx_d = r_max_idx;
      w_min_idx_d = r_min_idx;
      w_all_eq_d  = r_all_eq;

      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               w_state_d = StWait;
               w_count_d = '0;
            end
         end

         StWait: begin
            if (bus.in_valid) begin
               w_sample_d = bus.in_data;
               w_index_d  = IDX_W'(r_count);
               // Sample 0 seeds the result registers directly, no comparator pass needed.
               if (r_count == '0) begin
                  w_max_d     = bus.in_data;
                  w_min_d     = bus.in_data;
                  w_max_idx_d = '0;
                  w_min_idx_d = '0;
                  w_all_eq_d  = 1'b1;
                  w_count_d   = CNT_W'(1);
               end else begin
                  w_state_d = StCmpMax;
               end
            end
         end

         StCmpMax: begin
            if (w_gt) begin
               w_max_d     = r_sample;
               w_max_idx_d = r_index;
            end
            if (!w_eq) begin
               w_all_eq_d = 1'b0;
            end
            w_state_d = StCmpMin;
         end

         StCmpMin: begin
            if (w_lt) begin
               w_min_d     = r_sample;
               w_min_idx_d = r_index;
            end
            w_count_d = r_count + CNT_W'(1);
            w_state_d = (r_count == CNT_W'(FRAME_LEN - 1)) ? StDone : StWait;
         end

         StDone: begin
            if (bus.out_ready) begin
               w_state_d = StIdle;
            end
         end

         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   assign bus.in_ready  = (r_state == StWait);
   assign bus.out_valid = (r_state == StDone);
   assign bus.max_val   = r_max;
   assign bus.min_val   = r_min;
   assign bus.max_idx   = r_max_idx;
   assign bus.min_idx   = r_min_idx;
   assign bus.all_equal = r_all_eq;
   assign o_busy        = (r_state != StIdle);

endmodule

// File: tb/tb_mc_minmax_scheduler.sv
// Randomized scoreboard bench for mc_minmax_scheduler: frames are pushed with model results,
// a negedge monitor pops and compares on every result handshake.
module tb_mc_minmax_scheduler;

   localparam int W  = 4;
   localparam int N  = 8;
   localparam int IW = 4;

   typedef logic [W-1:0] frame_t [N];

   typedef struct {
      logic [W-1:0] mx;
      logic [W-1:0] mn;
      int           mxi;
      int           mni;
      bit           eq;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy;

   mc_minmax_scheduler_if #(.WIDTH(W), .IDX_W(IW)) bus ();

   mc_minmax_scheduler #(
      .WIDTH     (W),
      .FRAME_LEN (N),
      .IDX_W     (IW)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_start (start),
      .o_busy  (busy),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   exp_t sb[$];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: maximum/minimum by value, index = first position holding that value.
   function automatic exp_t model(input frame_t s);
      exp_t e;
      e.mx = s[0];
      e.mn = s[0];
      for (int i = 1; i < N; i++) begin
         if (s[i] > e.mx) e.mx = s[i];
         if (s[i] < e.mn) e.mn = s[i];
      end
      e.mxi = -1;
      e.mni = -1;
      for (int i = 0; i < N; i++) begin
         if (e.mxi < 0 && s[i] == e.mx) e.mxi = i;
         if (e.mni < 0 && s[i] == e.mn) e.mni = i;
      end
      e.eq = (e.mx == e.mn);
      return e;
   endfunction

   // Monitor: result accepted at the next posedge when valid and ready are both high here.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: out_valid handshake with empty scoreboard");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("max_val", 32'(bus.max_val), 32'(e.mx));
            check("min_val", 32'(bus.min_val), 32'(e.mn));
            check("max_idx", 32'(bus.max_idx), 32'(e.mxi));
            check("min_idx", 32'(bus.min_idx), 32'(e.mni));
            check("all_equal", 32'(bus.all_equal), 32'(e.eq));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [W-1:0] d, input bit bubbles);
      int  t;
      bit  acc;
      if (bubbles) begin
         int b;
         b = $urandom_range(0, 2);
         repeat (b) begin
            bus.in_valid = 1'b0;
            bus.in_data  = W'($urandom);
            tick();
         end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      t = 0;
      do begin
         @(negedge clk);
         acc = bus.in_ready;
         tick();
         t++;
      end while (!acc && t < 40);
      if (!acc) begin
         n_vec++;
         n_err++;
         $display("FAIL in_ready_timeout: got no in_ready, expected one within 40 cycles");
      end
   endtask

   task automatic run_frame(input frame_t s, input bit bubbles, input bit chk_lat,
                            input bit hold);
      exp_t e;
      int   s_cyc;
      int   t;
      e = model(s);
      sb.push_back(e);
      start = 1'b1;
      tick();
      s_cyc = cyc;
      start = 1'b0;
      for (int i = 0; i < N; i++) feed(s[i], bubbles);
      bus.in_valid = 1'b0;
      t = 0;
      while (!bus.out_valid && t < 40) begin
         tick();
         t++;
      end
      check("out_valid_rise", 32'(bus.out_valid), 32'd1);
      if (chk_lat) check("latency", 32'(cyc - s_cyc + 1), 32'd23);
      if (hold) begin
         repeat (10) tick();
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_max", 32'(bus.max_val), 32'(e.mx));
         check("hold_min", 32'(bus.min_val), 32'(e.mn));
         start = 1'b1;
         tick();
         start = 1'b0;
         check("start_in_done_valid", 32'(bus.out_valid), 32'd1);
         check("start_in_done_busy", 32'(busy), 32'd1);
      end
      // Start coincident with the handshake must be ignored.
      bus.out_ready = 1'b1;
      start         = hold;
      tick();
      bus.out_ready = 1'b0;
      start         = 1'b0;
      check("post_ack_busy", 32'(busy), 32'd0);
      check("post_ack_valid", 32'(bus.out_valid), 32'd0);
      check("retain_max", 32'(bus.max_val), 32'(e.mx));
      tick();
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_max_val"}, 32'(bus.max_val), 32'd0);
      check({tag, "_min_val"}, 32'(bus.min_val), 32'd0);
      check({tag, "_max_idx"}, 32'(bus.max_idx), 32'd0);
      check({tag, "_min_idx"}, 32'(bus.min_idx), 32'd0);
      check({tag, "_all_equal"}, 32'(bus.all_equal), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_t fr;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      #1;
      check_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Abort mid-frame with an asynchronous reset.
      start = 1'b1;
      tick();
      start = 1'b0;
      feed(4'd3, 1'b0);
      feed(4'd9, 1'b0);
      feed(4'd1, 1'b0);
      bus.in_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) tick();
      check("midreset_no_result", 32'(bus.out_valid), 32'd0);
      check("midreset_idle", 32'(busy), 32'd0);

      fr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
      run_frame(fr, 1'b0, 1'b1, 1'b0);
      fr = '{4'd5, 4'd9, 4'd2, 4'd9, 4'd2, 4'd5, 4'd3, 4'd4};
      run_frame(fr, 1'b0, 1'b1, 1'b0);
      fr = '{default: 4'd10};
      run_frame(fr, 1'b0, 1'b1, 1'b0);
      fr = '{4'd15, 4'd0, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
      run_frame(fr, 1'b0, 1'b1, 1'b0);
      fr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
      run_frame(fr, 1'b1, 1'b0, 1'b1);
      fr = '{4'd15, 4'd15, 4'd0, 4'd0, 4'd15, 4'd0, 4'd7, 4'd8};
      run_frame(fr, 1'b0, 1'b1, 1'b0);

      for (int f = 0; f < 12; f++) begin
         bit narrow;
         narrow = ($urandom_range(0, 1) == 1);
         for (int i = 0; i < N; i++) begin
            fr[i] = narrow ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 15));
         end
         run_frame(fr, ($urandom_range(0, 1) == 1), 1'b0, ($urandom_range(0, 3) == 0));
      end

      repeat (3) tick();
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
